// File: rtl/cache_access_gen_if.sv
// cache_access_gen_if
//   Groups the control/config inputs and the cache-facing outputs of
//   cache_access_gen into one bundle.
//   master : the controlling side (testbench). It drives start/config/stall
//            and observes addr/rd_en/busy/done/issued.
//   slave  : the generator itself.
interface cache_access_gen_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  start;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [15:0]           stride;
    logic [15:0]           wset_len;
    logic [CNT_WIDTH-1:0]  num_access;
    logic                  stall;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_en;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  issued;

    modport master (
        output start, mode, base_addr, stride, wset_len, num_access, stall,
        input  addr, rd_en, busy, done, issued
    );

    modport slave (
        input  start, mode, base_addr, stride, wset_len, num_access, stall,
        output addr, rd_en, busy, done, issued
    );
endinterface

// File: rtl/cache_access_gen.sv
// cache_access_gen
//   Programmable read-address stream generator for a cache controller.
//   It replays one of three patterns for a programmed number of accesses:
//   SEQ (constant stride), LOOP (strided working set that wraps back to base),
//   or RAND (base plus a 16-bit Galois LFSR value, word aligned).
//   Ports:
//     clk, rst        clock / asynchronous active-high reset
//     bus (slave)     start, mode, base_addr, stride, wset_len, num_access,
//                     stall in; addr, rd_en, busy, done, issued out
//   Every output comes straight from a flop.
module cache_access_gen #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    cache_access_gen_if.slave bus
);
    localparam logic [1:0] MODE_LOOP = 2'd1;
    localparam logic [1:0] MODE_RAND = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           stride_q, stride_d;
    logic [15:0]           wset_q, wset_d;
    logic [15:0]           idx_q, idx_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] stride_ext;
    logic [ADDR_WIDTH-1:0] rand_off;
    logic [CNT_WIDTH-1:0]  issued_inc;

    assign stride_ext = ADDR_WIDTH'(stride_q);
    // Random offsets are word aligned: the two LFSR lsbs are dropped.
    assign rand_off   = ADDR_WIDTH'({lfsr_q[15:2], 2'b00});
    assign issued_inc = issued_q + CNT_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        cur_d    = cur_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        wset_d   = wset_q;
        idx_d    = idx_q;
        lfsr_d   = lfsr_q;
        num_d    = num_q;
        issued_d = issued_q;
        rd_en_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d   = bus.mode;
                    base_d   = bus.base_addr;
                    stride_d = bus.stride;
                    // A zero-length working set behaves as a single entry.
                    wset_d   = (bus.wset_len == 16'd0) ? 16'd1 : bus.wset_len;
                    num_d    = bus.num_access;
                    cur_d    = bus.base_addr;
                    idx_d    = 16'd0;
                    issued_d = '0;
                    lfsr_d   = LFSR_SEED;
                    state_d  = (bus.num_access == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // While stalled every piece of pattern state simply holds.
                if (!bus.stall) begin
                    rd_en_d  = 1'b1;
                    issued_d = issued_inc;
                    case (mode_q)
                        MODE_RAND: begin
                            addr_d = base_q + rand_off;
                            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
                        end
                        MODE_LOOP: begin
                            addr_d = cur_q;
                            if (idx_q == wset_q - 16'd1) begin
                                cur_d = base_q;
                                idx_d = 16'd0;
                            end else begin
                                cur_d = cur_q + stride_ext;
                                idx_d = idx_q + 16'd1;
                            end
                        end
                        default: begin
                            // SEQ, and mode 3 aliases to SEQ.
                            addr_d = cur_q;
                            cur_d  = cur_q + stride_ext;
                        end
                    endcase
                    if (issued_inc == num_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // busy is registered from the next state so it tracks RUN/DONE exactly.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'd0;
            base_q   <= '0;
            cur_q    <= '0;
            addr_q   <= '0;
            stride_q <= 16'd0;
            wset_q   <= 16'd0;
            idx_q    <= 16'd0;
            lfsr_q   <= LFSR_SEED;
            num_q    <= '0;
            issued_q <= '0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            cur_q    <= cur_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            wset_q   <= wset_d;
            idx_q    <= idx_d;
            lfsr_q   <= lfsr_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.addr   = addr_q;
    assign bus.rd_en  = rd_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.issued = issued_q;

endmodule

// File: tb/tb_cache_access_gen.sv
// tb_cache_access_gen
//   Drives cache_access_gen through directed and randomized runs and compares
//   every cycle against an address list computed from the pattern rules.
module tb_cache_access_gen;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [31:0] cap_q[$];

    cache_access_gen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();

    cache_access_gen #(.ADDR_WIDTH(32), .CNT_WIDTH(32), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full run: program, start, then check every cycle until the done pulse.
    task automatic do_run(input string nm, input logic [1:0] m, input logic [31:0] b,
                          input logic [15:0] s, input logic [15:0] w, input logic [31:0] n,
                          input logic [63:0] stall_mask, input int stall_pct, input bit poke_start);
        logic [31:0] exp_q[$];
        logic [15:0] lf;
        logic [31:0] prev_addr;
        int weff, got, iter;
        bit fin, st;
        lf   = 16'hACE1;
        weff = (w == 16'd0) ? 1 : int'(w);
        for (int i = 0; i < int'(n); i++) begin
            case (m)
                2'd1: exp_q.push_back(b + 32'(i % weff) * {16'd0, s});
                2'd2: begin
                    exp_q.push_back(b + {16'd0, lf[15:2], 2'b00});
                    lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
                end
                default: exp_q.push_back(b + 32'(i) * {16'd0, s});
            endcase
        end
        cap_q.delete();

        @(negedge clk);
        bus.mode = m; bus.base_addr = b; bus.stride = s; bus.wset_len = w;
        bus.num_access = n; bus.stall = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        // Config is don't-care once accepted; scramble it.
        bus.start = 1'b0; bus.mode = 2'($urandom); bus.base_addr = $urandom;
        bus.stride = 16'($urandom); bus.wset_len = 16'($urandom); bus.num_access = $urandom_range(1, 9);
        n_chk++;
        if (bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start+1: busy=%b rd_en=%b done=%b required 1 0 0", nm, bus.busy, bus.rd_en, bus.done);
        end
        prev_addr = bus.addr;
        got = 0; fin = 1'b0; iter = 0;
        while (!fin && iter < 300) begin
            st = (iter < 64 && stall_mask[iter]) || ($urandom_range(99) < stall_pct);
            bus.stall = st;
            bus.start = poke_start && ($urandom_range(3) == 0);
            @(negedge clk);
            if (got < int'(n)) begin
                n_chk++;
                if (bus.rd_en !== !st || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d ctl: rd_en=%b done=%b busy=%b required rd_en=%b done=0 busy=1",
                             nm, iter, bus.rd_en, bus.done, bus.busy, !st);
                end
                if (bus.rd_en === 1'b1) begin
                    n_chk++;
                    if (bus.addr !== exp_q[got]) begin
                        n_fail++;
                        $display("FAIL %s addr#%0d: got %h required %h", nm, got, bus.addr, exp_q[got]);
                    end
                    cap_q.push_back(bus.addr);
                    got++;
                    n_chk++;
                    if (bus.issued !== 32'(got)) begin
                        n_fail++;
                        $display("FAIL %s issued: got %0d required %0d", nm, bus.issued, got);
                    end
                end else begin
                    n_chk++;
                    if (bus.addr !== prev_addr) begin
                        n_fail++;
                        $display("FAIL %s addr hold: got %h required %h", nm, bus.addr, prev_addr);
                    end
                end
            end else begin
                n_chk++;
                if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.issued !== n) begin
                    n_fail++;
                    $display("FAIL %s done cycle: done=%b busy=%b rd_en=%b issued=%0d required 1 0 0 %0d",
                             nm, bus.done, bus.busy, bus.rd_en, bus.issued, n);
                end
                fin = 1'b1;
            end
            prev_addr = bus.addr;
            iter++;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s timeout: issued %0d of %0d, no done", nm, got, n);
        end
        @(negedge clk);
        n_chk++;
        if (bus.done !== 1'b0 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.issued !== n) begin
            n_fail++;
            $display("FAIL %s after done: done=%b rd_en=%b busy=%b issued=%0d required 0 0 0 %0d",
                     nm, bus.done, bus.rd_en, bus.busy, bus.issued, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 2'd0; bus.base_addr = '0; bus.stride = '0;
        bus.wset_len = '0; bus.num_access = '0; bus.stall = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.addr !== 32'd0 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.issued !== 32'd0) begin
            n_fail++;
            $display("FAIL reset values: addr=%h rd_en=%b busy=%b done=%b issued=%0d required all 0",
                     bus.addr, bus.rd_en, bus.busy, bus.done, bus.issued);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_seq();
        do_run("seq", 2'd0, 32'h1000, 16'd32, 16'd0, 32'd4, 64'd0, 0, 1'b0);
    endtask

    task automatic test_loop();
        do_run("loop", 2'd1, 32'h0, 16'h2000, 16'd5, 32'd12, 64'd0, 0, 1'b0);
        n_chk++;
        if (cap_q.size() != 12 || cap_q[5] !== 32'h0 || cap_q[4] !== 32'h8000) begin
            n_fail++;
            $display("FAIL loop wrap: n=%0d cap[4]=%h cap[5]=%h required 12 8000 0",
                     cap_q.size(), cap_q[4], cap_q[5]);
        end
    endtask

    task automatic test_rand();
        logic [31:0] first[$];
        logic [31:0] ref4[4];
        ref4 = '{32'hACE0, 32'hE270, 32'h7138, 32'h389C};
        do_run("rand1", 2'd2, 32'h0, 16'd0, 16'd0, 32'd8, 64'd0, 0, 1'b0);
        first = cap_q;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (first.size() <= i || first[i] !== ref4[i]) begin
                n_fail++;
                $display("FAIL rand first#%0d: got %h required %h", i, (first.size() > i) ? first[i] : 32'hx, ref4[i]);
            end
        end
        do_run("rand2", 2'd2, 32'h0, 16'd0, 16'd0, 32'd8, 64'd0, 30, 1'b1);
        n_chk++;
        if (cap_q != first) begin
            n_fail++;
            $display("FAIL rand replay: second run differs (size %0d vs %0d)", cap_q.size(), first.size());
        end
    endtask

    task automatic test_stall();
        // Issue two, stall for three cycles, then finish; start pokes must be ignored.
        do_run("stall", 2'd0, 32'h1000, 16'd32, 16'd0, 32'd4, 64'b11100, 0, 1'b1);
    endtask

    task automatic test_zero();
        do_run("zero", 2'd0, 32'h2000, 16'd4, 16'd0, 32'd0, 64'd0, 0, 1'b0);
    endtask

    task automatic test_midrun_reset();
        int seen, cyc;
        @(negedge clk);
        bus.mode = 2'd0; bus.base_addr = 32'h3000; bus.stride = 16'd4;
        bus.num_access = 32'd6; bus.stall = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            if (bus.rd_en === 1'b1) seen++;
            cyc++;
        end
        n_chk++;
        if (seen < 2) begin
            n_fail++;
            $display("FAIL midrst wait: saw %0d accesses required 2", seen);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.rd_en !== 1'b0 || bus.issued !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst async: rd_en=%b issued=%0d busy=%b done=%b required 0 0 0 0",
                     bus.rd_en, bus.issued, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_chk++;
            if (bus.done !== 1'b0 || bus.rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst quiet: done=%b rd_en=%b required 0 0", bus.done, bus.rd_en);
            end
        end
        do_run("after_rst", 2'd0, 32'h3000, 16'd4, 16'd0, 32'd6, 64'd0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_run("random", 2'($urandom_range(3)), $urandom, 16'($urandom), 16'($urandom_range(0, 6)),
                   32'($urandom_range(0, 20)), 64'd0, 25, 1'b1);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_seq();
        test_loop();
        test_rand();
        test_stall();
        test_zero();
        test_midrun_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
